pipeline_result_queue: RTL and testbench

- Sits directly downstream of the stall-capable address pipeline; consumes its address/id/valid stream and drives its in_stall backpressure.
- Buffers up to DEPTH results in a circular queue and presents them in order to the consumer on a valid/ready handshake.
- Implements selective flush: every buffered or arriving entry whose id matches the flush id is dropped before it reaches the consumer.

---
 rtl/pipeline_result_queue.sv | 112 +++++++++++
 tb/tb_pipeline_result_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_result_queue.sv
// In-order result queue behind the address pipeline with per-id selective flush.
// Killed entries retire silently at the head and pulse out_drop.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module pipeline_result_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = `ADDRESS_WIDTH,
    parameter int unsigned ID_W   = `ID_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        in_address,
    input  logic [ID_W-1:0]          in_id,
    input  logic                     in_valid,
    output logic                     out_stall,
    input  logic                     in_flush,
    input  logic [ID_W-1:0]          in_flush_id,
    output logic [ADDR_W-1:0]        out_address,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_valid,
    input  logic                     in_ready,
    output logic                     out_drop,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [DEPTH-1:0]  live_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              occupied_c;
    logic              head_live_c;
    logic              push_c;
    logic              pop_c;
    logic              push_live_c;
    logic [DEPTH-1:0]  kill_c;

    // Output view of the head entry, derived only from registered state.
    always_comb begin
        occupied_c  = (count_q != '0);
        head_live_c = live_q[rd_ptr_q];
        out_stall   = (count_q == CNT_W'(DEPTH));
        out_valid   = occupied_c && head_live_c;
        out_drop    = occupied_c && !head_live_c;
        out_address = addr_q[rd_ptr_q];
        out_id      = id_q[rd_ptr_q];
        out_count   = count_q;
    end

    always_comb begin
        push_c      = in_valid && !out_stall;
        pop_c       = (out_valid && in_ready) || out_drop;
        push_live_c = !(in_flush && (in_id == in_flush_id));
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        count_d     = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Slot i is occupied when its distance from the head is below count.
    always_comb begin
        kill_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off = PTR_W'(i) - rd_ptr_q;
            kill_c[i] = in_flush && (CNT_W'(off) < count_q) && (id_q[i] == in_flush_id);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_c[i]) begin
                    live_q[i] <= 1'b0;
                end
            end
            // The push slot is never occupied, so it cannot collide with a kill.
            if (push_c) begin
                addr_q[wr_ptr_q] <= in_address;
                id_q[wr_ptr_q]   <= in_id;
                live_q[wr_ptr_q] <= push_live_c;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_result_queue.sv
// Directed bench for pipeline_result_queue (DEPTH=4, ADDR_W=16, ID_W=4).
module tb_pipeline_result_queue;

    logic        clk;
    logic        reset;
    logic [15:0] in_address;
    logic [3:0]  in_id;
    logic        in_valid;
    logic        out_stall;
    logic        in_flush;
    logic [3:0]  in_flush_id;
    logic [15:0] out_address;
    logic [3:0]  out_id;
    logic        out_valid;
    logic        in_ready;
    logic        out_drop;
    logic [2:0]  out_count;

    int errors = 0;
    int checks = 0;

    pipeline_result_queue #(.DEPTH(4), .ADDR_W(16), .ID_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_address  (in_address),
        .in_id       (in_id),
        .in_valid    (in_valid),
        .out_stall   (out_stall),
        .in_flush    (in_flush),
        .in_flush_id (in_flush_id),
        .out_address (out_address),
        .out_id      (out_id),
        .out_valid   (out_valid),
        .in_ready    (in_ready),
        .out_drop    (out_drop),
        .out_count   (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] id, input logic [15:0] addr);
        in_valid   = 1'b1;
        in_id      = id;
        in_address = addr;
        tick();
        in_valid   = 1'b0;
    endtask

    int unsigned exp_q[$];
    int unsigned sent;
    int unsigned delivered;
    int unsigned cycles;
    logic        rdy_toggle;
    logic        exp_stall;
    logic        exp_valid;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_address = '0; in_id = '0;
        in_flush = 1'b0; in_flush_id = '0; in_ready = 1'b0;
        tick(); tick();
        chk("rst_count", 32'(out_count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_stall", 32'(out_stall), 0);
        chk("rst_drop",  32'(out_drop), 0);
        chk("rst_addr",  32'(out_address), 0);
        reset = 1'b0;
        tick();

        // In-order delivery of three entries
        push(4'd1, 16'h0010);
        chk("t1_valid_after_push", 32'(out_valid), 1);
        chk("t1_id_after_push", 32'(out_id), 1);
        push(4'd2, 16'h0020);
        push(4'd3, 16'h0030);
        chk("t1_count3", 32'(out_count), 3);
        chk("t1_addr_head", 32'(out_address), 32'h10);
        in_ready = 1'b1;
        chk("t1_id1", 32'(out_id), 1);
        tick();
        chk("t1_id2", 32'(out_id), 2);
        chk("t1_addr2", 32'(out_address), 32'h20);
        tick();
        chk("t1_id3", 32'(out_id), 3);
        chk("t1_valid3", 32'(out_valid), 1);
        tick();
        chk("t1_empty_valid", 32'(out_valid), 0);
        chk("t1_empty_count", 32'(out_count), 0);
        in_ready = 1'b0;

        // Full queue backpressure, full+pop does not push
        for (int k = 1; k <= 4; k++) push(4'(k), 16'(32'h100 + k));
        chk("t2_full_count", 32'(out_count), 4);
        chk("t2_stall", 32'(out_stall), 1);
        in_valid = 1'b1; in_id = 4'd5; in_address = 16'h0105;
        tick();
        chk("t2_no_push_full", 32'(out_count), 4);
        chk("t2_head_still1", 32'(out_id), 1);
        in_ready = 1'b1;
        chk("t2_stall_during_pop", 32'(out_stall), 1);
        tick();
        chk("t2_count_after_pop", 32'(out_count), 3);
        chk("t2_stall_released", 32'(out_stall), 0);
        in_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t2_held_accepted", 32'(out_count), 4);
        in_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("t2_drain_id", 32'(out_id), 32'(k));
            chk("t2_drain_addr", 32'(out_address), 32'h100 + k);
            tick();
        end
        chk("t2_drained", 32'(out_count), 0);
        in_ready = 1'b0;

        // Selective flush of id 2 among 2,5,2,7
        push(4'd2, 16'h0a00); push(4'd5, 16'h0a01);
        push(4'd2, 16'h0a02); push(4'd7, 16'h0a03);
        in_flush = 1'b1; in_flush_id = 4'd2;
        tick();
        in_flush = 1'b0; in_flush_id = 4'd0;
        chk("t3_count4", 32'(out_count), 4);
        chk("t3_valid0", 32'(out_valid), 0);
        chk("t3_drop1", 32'(out_drop), 1);
        in_ready = 1'b1;
        tick();
        chk("t3_id5", 32'(out_id), 5);
        chk("t3_valid5", 32'(out_valid), 1);
        chk("t3_drop_low", 32'(out_drop), 0);
        chk("t3_count3", 32'(out_count), 3);
        tick();
        chk("t3_drop2", 32'(out_drop), 1);
        chk("t3_valid_killed", 32'(out_valid), 0);
        tick();
        chk("t3_id7", 32'(out_id), 7);
        chk("t3_addr7", 32'(out_address), 32'ha03);
        tick();
        chk("t3_empty", 32'(out_count), 0);
        chk("t3_no_drop", 32'(out_drop), 0);
        in_ready = 1'b0;

        // Flush matching a same-cycle push into an empty queue
        in_valid = 1'b1; in_id = 4'd9; in_address = 16'h0900;
        in_flush = 1'b1; in_flush_id = 4'd9;
        tick();
        in_valid = 1'b0; in_flush = 1'b0;
        chk("t4_count1", 32'(out_count), 1);
        chk("t4_valid0", 32'(out_valid), 0);
        chk("t4_drop", 32'(out_drop), 1);
        tick();
        chk("t4_count0", 32'(out_count), 0);
        chk("t4_drop_gone", 32'(out_drop), 0);

        // Handshake wins over flush on the head
        push(4'd3, 16'h0033);
        push(4'd3, 16'h0034);
        chk("t5_head_valid", 32'(out_valid), 1);
        in_ready = 1'b1; in_flush = 1'b1; in_flush_id = 4'd3;
        chk("t5_head_addr", 32'(out_address), 32'h33);
        tick();
        in_flush = 1'b0;
        chk("t5_second_killed", 32'(out_valid), 0);
        chk("t5_second_drop", 32'(out_drop), 1);
        chk("t5_count1", 32'(out_count), 1);
        tick();
        chk("t5_empty", 32'(out_count), 0);
        in_ready = 1'b0;

        // Streaming across pointer wrap with ready toggling 1,0
        sent = 0; delivered = 0; cycles = 0; rdy_toggle = 1'b1;
        while (delivered < 12 && cycles < 200) begin
            in_valid   = (sent < 12);
            in_id      = 4'(sent);
            in_address = 16'(32'h200 + sent);
            in_ready   = rdy_toggle;
            exp_stall  = (exp_q.size() == 4);
            exp_valid  = (exp_q.size() != 0);
            chk("t6_stall", 32'(out_stall), 32'(exp_stall));
            chk("t6_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid && rdy_toggle) begin
                chk("t6_id", 32'(out_id), 32'(4'(exp_q[0])));
                chk("t6_addr", 32'(out_address), 32'h200 + exp_q[0]);
                void'(exp_q.pop_front());
                delivered++;
            end
            if (in_valid && !exp_stall) begin
                exp_q.push_back(sent);
                sent++;
            end
            tick();
            rdy_toggle = ~rdy_toggle;
            cycles++;
        end
        chk("t6_all_delivered", delivered, 12);
        in_valid = 1'b0; in_ready = 1'b0;
        chk("t6_final_count", 32'(out_count), 0);

        // Reset mid-stream discards contents and in-flight push/pop
        push(4'd1, 16'h0301); push(4'd2, 16'h0302); push(4'd3, 16'h0303);
        in_valid = 1'b1; in_id = 4'd4; in_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_count", 32'(out_count), 0);
        chk("t6_rst_stall", 32'(out_stall), 0);
        tick();
        chk("t6_rst_stays_empty", 32'(out_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
